// File: rtl/layer_compositor_pipe.sv
// Pipelined N-layer pixel compositor: topmost opaque enabled layer wins, else background.
// Layer mask and background are shadowed at vsync onset; a per-frame collision flag is reported.
module layer_compositor_pipe #(
  parameter int unsigned           NUM_LAYERS = 4,
  parameter int unsigned           CW         = 4,
  parameter bit                    VSYNC_POL  = 1'b0,
  parameter bit                    HSYNC_POL  = 1'b0,
  parameter int unsigned           COLL_A     = 1,
  parameter int unsigned           COLL_B     = 2,
  parameter logic [NUM_LAYERS-1:0] EN_RESET   = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_hsync,
  input  logic                     in_vsync,
  input  logic                     in_valid,
  input  logic [NUM_LAYERS*CW-1:0] in_r,
  input  logic [NUM_LAYERS*CW-1:0] in_g,
  input  logic [NUM_LAYERS*CW-1:0] in_b,
  input  logic [NUM_LAYERS-1:0]    in_a,
  input  logic [NUM_LAYERS-1:0]    layer_en,
  input  logic [3*CW-1:0]          bg_rgb,
  output logic                     out_hsync,
  output logic                     out_vsync,
  output logic                     out_valid,
  output logic [CW-1:0]            out_r,
  output logic [CW-1:0]            out_g,
  output logic [CW-1:0]            out_b,
  output logic [NUM_LAYERS-1:0]    out_hit,
  output logic                     collision,
  output logic                     frame_start
);

  localparam int unsigned N  = NUM_LAYERS;
  localparam int unsigned LW = NUM_LAYERS * CW;
  localparam int unsigned PW = 3 * CW;

  logic          vs_prev_q;
  logic          fs_edge;
  logic [N-1:0]  mask_q, eff_mask;
  logic [PW-1:0] bg_q, eff_bg;
  logic          acc_q, coll_q, fs_q;
  logic          overlap;

  // A pixel arriving on the frame-start edge already sees the newly loaded shadows.
  always_comb begin
    fs_edge  = (in_vsync == VSYNC_POL) && (vs_prev_q != VSYNC_POL);
    eff_mask = fs_edge ? layer_en : mask_q;
    eff_bg   = fs_edge ? bg_rgb : bg_q;
    overlap  = in_valid & in_a[COLL_A] & in_a[COLL_B] & eff_mask[COLL_A] & eff_mask[COLL_B];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q <= ~VSYNC_POL;
      mask_q    <= EN_RESET;
      bg_q      <= '0;
      acc_q     <= 1'b0;
      coll_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      vs_prev_q <= in_vsync;
      fs_q      <= fs_edge;
      mask_q    <= eff_mask;
      bg_q      <= eff_bg;
      if (fs_edge) begin
        coll_q <= acc_q;
        acc_q  <= overlap;
      end else begin
        acc_q  <= acc_q | overlap;
      end
    end
  end

  logic          valid_q [N+1];
  logic          hs_q    [N+1];
  logic          vs_q    [N+1];
  logic [N-1:0]  hit_q   [N+1];
  logic [LW-1:0] lr_q    [N+1];
  logic [LW-1:0] lg_q    [N+1];
  logic [LW-1:0] lb_q    [N+1];
  logic [PW-1:0] res_q   [N+1];

  // Stage 0: invalid pixels are zeroed here so they stay zero down the whole pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q[0] <= 1'b0;
      hs_q[0]    <= ~HSYNC_POL;
      vs_q[0]    <= ~VSYNC_POL;
      hit_q[0]   <= '0;
      lr_q[0]    <= '0;
      lg_q[0]    <= '0;
      lb_q[0]    <= '0;
      res_q[0]   <= '0;
    end else begin
      valid_q[0] <= in_valid;
      hs_q[0]    <= in_hsync;
      vs_q[0]    <= in_vsync;
      hit_q[0]   <= in_valid ? (in_a & eff_mask) : '0;
      lr_q[0]    <= in_r;
      lg_q[0]    <= in_g;
      lb_q[0]    <= in_b;
      res_q[0]   <= in_valid ? eff_bg : '0;
    end
  end

  for (genvar k = 1; k <= N; k++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        hs_q[k]    <= ~HSYNC_POL;
        vs_q[k]    <= ~VSYNC_POL;
        hit_q[k]   <= '0;
        lr_q[k]    <= '0;
        lg_q[k]    <= '0;
        lb_q[k]    <= '0;
        res_q[k]   <= '0;
      end else begin
        valid_q[k] <= valid_q[k-1];
        hs_q[k]    <= hs_q[k-1];
        vs_q[k]    <= vs_q[k-1];
        hit_q[k]   <= hit_q[k-1];
        lr_q[k]    <= lr_q[k-1];
        lg_q[k]    <= lg_q[k-1];
        lb_q[k]    <= lb_q[k-1];
        // Bottom-up resolution: a higher opaque layer overwrites the running result.
        res_q[k]   <= hit_q[k-1][k-1] ? {lr_q[k-1][(k-1)*CW +: CW], lg_q[k-1][(k-1)*CW +: CW],
                                         lb_q[k-1][(k-1)*CW +: CW]} : res_q[k-1];
      end
    end
  end

  assign out_hsync   = hs_q[N];
  assign out_vsync   = vs_q[N];
  assign out_valid   = valid_q[N];
  assign out_r       = res_q[N][PW-1 -: CW];
  assign out_g       = res_q[N][2*CW-1 -: CW];
  assign out_b       = res_q[N][CW-1:0];
  assign out_hit     = hit_q[N];
  assign collision   = coll_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_layer_compositor_pipe.sv
// Randomized and directed bench for layer_compositor_pipe against a priority-search model.
module tb_layer_compositor_pipe;
  localparam int N  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_hs = 1'b1, i_vs = 1'b1, i_valid = 1'b0;
  logic [N*CW-1:0] i_r = '0, i_g = '0, i_b = '0;
  logic [N-1:0] i_a = '0, i_en = '1;
  logic [3*CW-1:0] i_bg = '0;
  logic o_hs, o_vs, o_valid, o_coll, o_fs;
  logic [CW-1:0] o_r, o_g, o_b;
  logic [N-1:0] o_hit;

  always #5 clk = ~clk;

  layer_compositor_pipe dut (
    .clk(clk), .rst(rst), .in_hsync(i_hs), .in_vsync(i_vs), .in_valid(i_valid),
    .in_r(i_r), .in_g(i_g), .in_b(i_b), .in_a(i_a), .layer_en(i_en), .bg_rgb(i_bg),
    .out_hsync(o_hs), .out_vsync(o_vs), .out_valid(o_valid), .out_r(o_r), .out_g(o_g),
    .out_b(o_b), .out_hit(o_hit), .collision(o_coll), .frame_start(o_fs)
  );

  typedef struct packed {
    logic          v, hs, vs;
    logic [3*CW-1:0] rgb;
    logic [N-1:0]  hit;
  } exp_t;

  exp_t q[$];
  logic [N-1:0]    m_mask;
  logic [3*CW-1:0] m_bg;
  logic m_prev_vs, m_acc, m_coll, e_fs, e_coll;
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_t e;
    e = '{v: 1'b0, hs: 1'b1, vs: 1'b1, rgb: '0, hit: '0};
    q.delete();
    for (int i = 0; i <= N; i++) q.push_back(e);
    m_mask = '1; m_bg = '0; m_prev_vs = 1'b1; m_acc = 1'b0; m_coll = 1'b0;
    e_fs = 1'b0; e_coll = 1'b0;
  endtask

  // Called at a falling edge: check outputs, then apply the staged inputs for the next edge.
  task automatic cycle();
    exp_t e, n;
    logic edge_v, found;
    e = q.pop_front();
    chk("valid", 32'(o_valid), 32'(e.v));
    chk("hsync", 32'(o_hs), 32'(e.hs));
    chk("vsync", 32'(o_vs), 32'(e.vs));
    chk("rgb", {20'h0, o_r, o_g, o_b}, 32'(e.rgb));
    chk("hit", 32'(o_hit), 32'(e.hit));
    chk("frame_start", 32'(o_fs), 32'(e_fs));
    chk("collision", 32'(o_coll), 32'(e_coll));
    edge_v = (i_vs == 1'b0) && (m_prev_vs == 1'b1);
    m_prev_vs = i_vs;
    if (edge_v) begin
      m_mask = i_en; m_bg = i_bg; m_coll = m_acc; m_acc = 1'b0;
    end
    if (i_valid && i_a[1] && i_a[2] && m_mask[1] && m_mask[2]) m_acc = 1'b1;
    e_fs = edge_v; e_coll = m_coll;
    n.v = i_valid; n.hs = i_hs; n.vs = i_vs;
    n.hit = i_valid ? (i_a & m_mask) : '0;
    n.rgb = i_valid ? m_bg : '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (n.hit[i] && !found) begin
        n.rgb = {i_r[i*CW +: CW], i_g[i*CW +: CW], i_b[i*CW +: CW]};
        found = 1'b1;
      end
    end
    q.push_back(n);
    @(negedge clk);
  endtask

  task automatic vpulse();
    i_vs = 1'b0; cycle();
    i_vs = 1'b1; cycle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) cycle();
    chk("idle_r", 32'(o_r), 0); chk("idle_valid", 32'(o_valid), 0);
    chk("idle_vsync", 32'(o_vs), 1); chk("idle_hsync", 32'(o_hs), 1);
    chk("idle_coll", 32'(o_coll), 0);

    // Latency: one pixel, layer2 0F0 over layer0 F00.
    i_valid = 1'b1; i_r = 16'h000F; i_g = 16'h0F00; i_b = '0; i_a = 4'b0101;
    cycle();
    i_valid = 1'b0; i_a = '0;
    repeat (3) cycle();
    chk("lat_early_valid", 32'(o_valid), 0);
    cycle();
    chk("lat_valid", 32'(o_valid), 1);
    chk("lat_rgb", {20'h0, o_r, o_g, o_b}, 32'h0F0);
    chk("lat_hit", 32'(o_hit), 32'b0101);

    // Background shadowing.
    i_bg = 12'h00F; vpulse();
    i_valid = 1'b1; i_a = '0;
    repeat (6) cycle();
    chk("bg_rgb", {20'h0, o_r, o_g, o_b}, 32'h00F);
    i_bg = 12'hFFF;
    repeat (6) cycle();
    chk("bg_hold", {20'h0, o_r, o_g, o_b}, 32'h00F);

    // Layer-enable shadowing: layer2 disabled.
    i_en = 4'b1011; vpulse();
    i_r = 16'h000F; i_g = 16'h0F00; i_b = '0; i_a = 4'b0101;
    repeat (6) cycle();
    chk("en_rgb", {20'h0, o_r, o_g, o_b}, 32'hF00);
    chk("en_hit", 32'(o_hit), 32'b0001);

    // Collision across frames k, k+1, k+2.
    i_en = 4'b1111; i_a = '0; vpulse();
    i_a = 4'b0110; cycle();
    i_a = '0; repeat (3) cycle();
    vpulse();
    chk("coll_set", 32'(o_coll), 1);
    repeat (3) cycle();
    vpulse();
    chk("coll_clr", 32'(o_coll), 0);

    // Reset mid-line with a full pipeline.
    for (int i = 0; i < 8; i++) begin
      i_r = 16'($urandom); i_g = 16'($urandom); i_b = 16'($urandom); i_a = 4'($urandom);
      i_hs = 1'b0; cycle();
    end
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(o_valid), 0); chk("rst_rgb", {20'h0, o_r, o_g, o_b}, 0);
    chk("rst_hsync", 32'(o_hs), 1); chk("rst_hit", 32'(o_hit), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    i_hs = 1'b1; i_r = 16'h0A00; i_g = 16'h0500; i_b = 16'h0300; i_a = 4'b0100;
    cycle();
    i_valid = 1'b0;
    repeat (4) cycle();
    chk("post_rst_rgb", {20'h0, o_r, o_g, o_b}, 32'hA53);

    // Random traffic with random shadow requests and occasional vsync pulses/glitches.
    for (int i = 0; i < 2000; i++) begin
      i_valid = ($urandom_range(0, 9) != 0);
      i_hs = ($urandom_range(0, 15) != 0);
      i_vs = (i_vs == 1'b0) ? ($urandom_range(0, 2) == 0 ? 1'b0 : 1'b1)
                            : ($urandom_range(0, 39) != 0);
      i_r = 16'($urandom); i_g = 16'($urandom); i_b = 16'($urandom);
      i_a = 4'($urandom); i_en = 4'($urandom); i_bg = 12'($urandom);
      cycle();
    end
    repeat (N + 2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
